// File: rtl/bid_agent_if.sv
// Bidder <-> bid controller port: request/response handshake plus round and price status.
// The agent uses the master view; a controller model or the controller itself uses slave.
interface bid_agent_if;
    logic        bid;
    logic [15:0] bid_amt;
    logic        retract;
    logic        ack;
    logic [1:0]  err;
    logic        win;
    logic [31:0] balance;
    logic [31:0] max_bid;
    logic        round_active;
    logic        round_over;

    modport master (
        output bid, bid_amt, retract,
        input  ack, err, win, balance, max_bid, round_active, round_over
    );

    modport slave (
        input  bid, bid_amt, retract,
        output ack, err, win, balance, max_bid, round_active, round_over
    );
endinterface

// File: rtl/bid_agent.sv
// bid_agent: self-driving bidder that outbids max_bid by a step, up to a host limit and its balance.
// Define BID_AGENT_RETRACT_EN to retract the standing bid when the host drops en while leading.
module bid_agent #(
    parameter int TIMEOUT = 16,
    parameter int BACKOFF = 4
) (
    input  logic        clk,
    input  logic        reset,
    bid_agent_if.master bus,
    input  logic        i_en,
    input  logic [15:0] i_limit,
    input  logic [15:0] i_step,
    output logic        o_leading,
    output logic        o_won,
    output logic [1:0]  o_last_err,
    output logic        o_timeout,
    output logic [7:0]  o_bid_count
);
    // state          | meaning
    // IDLE           | evaluate whether a bid fits under limit and balance
    // WAIT_ACK       | bid pulse issued, waiting on ack or timeout
    // HOLD           | holding the accepted high bid
    // RETRACT        | retract pulse cycle
    // RETRACT_WAIT   | waiting on ack or timeout after the retract
    // BACKOFF        | idle spacing after an error or timeout
    // DONE           | one cycle after round_over
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_HOLD,
        S_BACKOFF,
        S_DONE
`ifdef BID_AGENT_RETRACT_EN
        , S_RETRACT,
        S_RETRACT_WAIT
`endif
    } state_t;

    localparam logic [15:0] TO_LOAD = 16'(TIMEOUT);
    localparam logic [15:0] BO_LOAD = 16'(BACKOFF);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic        r_bid;
    logic [15:0] r_bid_amt;
    logic        r_leading;
    logic        r_won;
    logic [1:0]  r_last_err;
    logic [7:0]  r_bid_count;
    logic        r_ra_d;

    logic [15:0] w_step_eff;
    logic [32:0] w_next;
    logic        w_fits;
    logic        w_expired;
    logic        w_ra_rise;
    logic        w_issue_bid;
    logic        w_ld_to;
    logic        w_ld_bo;
    logic        w_set_lead;
    logic        w_clr_lead;
    logic        w_inc;
    logic        w_err_ld;
    logic [1:0]  w_err_val;
    logic        w_latch_won;
    logic        w_timeout;

    assign w_step_eff = (i_step == 16'd0) ? 16'd1 : i_step;
    assign w_next     = {1'b0, bus.max_bid} + {17'd0, w_step_eff};
    assign w_fits     = (w_next <= {17'd0, i_limit}) && (w_next <= {1'b0, bus.balance});
    // The wait counter is loaded with TIMEOUT in the pulse cycle, so zero lands TIMEOUT cycles later.
    assign w_expired  = (r_cnt == 16'd0);
    assign w_ra_rise  = bus.round_active && !r_ra_d;

`ifdef BID_AGENT_RETRACT_EN
    logic r_retract;
    logic w_issue_ret;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue_bid = 1'b0;
        w_ld_to     = 1'b0;
        w_ld_bo     = 1'b0;
        w_set_lead  = 1'b0;
        w_clr_lead  = 1'b0;
        w_inc       = 1'b0;
        w_err_ld    = 1'b0;
        w_err_val   = 2'b00;
        w_latch_won = 1'b0;
        w_timeout   = 1'b0;
`ifdef BID_AGENT_RETRACT_EN
        w_issue_ret = 1'b0;
`endif
        if (bus.round_over) begin
            w_latch_won = 1'b1;
            w_clr_lead  = 1'b1;
            w_state_nxt = S_DONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_en && bus.round_active && w_fits) begin
                        w_issue_bid = 1'b1;
                        w_ld_to     = 1'b1;
                        w_state_nxt = S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    // An ack in the pulse cycle itself belongs to nobody and is dropped.
                    if (!r_bid) begin
                        if (bus.ack) begin
                            if (bus.err == 2'b00) begin
                                w_set_lead  = 1'b1;
                                w_inc       = 1'b1;
                                w_state_nxt = S_HOLD;
                            end else begin
                                w_err_ld    = 1'b1;
                                w_err_val   = bus.err;
                                w_ld_bo     = 1'b1;
                                w_state_nxt = S_BACKOFF;
                            end
                        end else if (w_expired) begin
                            w_timeout   = 1'b1;
                            w_err_ld    = 1'b1;
                            w_err_val   = 2'b11;
                            w_ld_bo     = 1'b1;
                            w_state_nxt = S_BACKOFF;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.max_bid > {16'd0, r_bid_amt}) begin
                        w_clr_lead  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
`ifdef BID_AGENT_RETRACT_EN
                    else if (!i_en && bus.round_active) begin
                        w_issue_ret = 1'b1;
                        w_ld_to     = 1'b1;
                        w_state_nxt = S_RETRACT;
                    end
`endif
                end
`ifdef BID_AGENT_RETRACT_EN
                S_RETRACT: w_state_nxt = S_RETRACT_WAIT;
                S_RETRACT_WAIT: begin
                    if (bus.ack) begin
                        w_clr_lead  = 1'b1;
                        w_err_ld    = (bus.err != 2'b00);
                        w_err_val   = bus.err;
                        w_state_nxt = S_IDLE;
                    end else if (w_expired) begin
                        w_timeout   = 1'b1;
                        w_clr_lead  = 1'b1;
                        w_err_ld    = 1'b1;
                        w_err_val   = 2'b11;
                        w_state_nxt = S_IDLE;
                    end
                end
`endif
                S_BACKOFF: begin
                    if (r_cnt <= 16'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= 16'd0;
            r_bid       <= 1'b0;
            r_bid_amt   <= 16'd0;
            r_leading   <= 1'b0;
            r_won       <= 1'b0;
            r_last_err  <= 2'b00;
            r_bid_count <= 8'd0;
            r_ra_d      <= 1'b0;
        end else begin
            r_bid  <= w_issue_bid;
            r_ra_d <= bus.round_active;
            if (w_issue_bid) begin
                r_bid_amt <= w_next[15:0];
            end
            if (w_ld_to) begin
                r_cnt <= TO_LOAD;
            end else if (w_ld_bo) begin
                r_cnt <= BO_LOAD;
            end else if (r_cnt != 16'd0) begin
                r_cnt <= r_cnt - 16'd1;
            end
            if (w_set_lead) begin
                r_leading <= 1'b1;
            end else if (w_clr_lead) begin
                r_leading <= 1'b0;
            end
            if (w_err_ld) begin
                r_last_err <= w_err_val;
            end
            if (w_latch_won) begin
                r_won <= bus.win;
            end else if (w_ra_rise) begin
                r_won <= 1'b0;
            end
            if (w_ra_rise) begin
                r_bid_count <= 8'd0;
            end else if (w_inc && r_bid_count != 8'hFF) begin
                r_bid_count <= r_bid_count + 8'd1;
            end
        end
    end

`ifdef BID_AGENT_RETRACT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retract <= 1'b0;
        end else begin
            r_retract <= w_issue_ret;
        end
    end
    assign bus.retract = r_retract;
`else
    assign bus.retract = 1'b0;
`endif

    assign bus.bid     = r_bid;
    assign bus.bid_amt = r_bid_amt;
    assign o_leading   = r_leading;
    assign o_won       = r_won;
    assign o_last_err  = r_last_err;
    assign o_timeout   = w_timeout;
    assign o_bid_count = r_bid_count;
endmodule

// File: tb/tb_bid_agent.sv
// Directed testbench for bid_agent: walks one agent through bid, outbid, error, timeout,
// retract, round end and reset scenarios against hand-computed expectations.
module tb_bid_agent;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] limit;
    logic [15:0] step_v;
    logic        leading;
    logic        won;
    logic [1:0]  last_err;
    logic        timeout;
    logic [7:0]  bid_count;

    int n_checks = 0;
    int n_fail   = 0;

    bid_agent_if bus();

    bid_agent #(.TIMEOUT(16), .BACKOFF(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .i_en        (en),
        .i_limit     (limit),
        .i_step      (step_v),
        .o_leading   (leading),
        .o_won       (won),
        .o_last_err  (last_err),
        .o_timeout   (timeout),
        .o_bid_count (bid_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bid(input int max_cyc, output int n);
        n = 0;
        while (bus.bid !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; limit = 16'd0; step_v = 16'd0;
        bus.ack = 1'b0; bus.err = 2'b00; bus.win = 1'b0; bus.balance = 32'd0;
        bus.max_bid = 32'd0; bus.round_active = 1'b0; bus.round_over = 1'b0;
        repeat (3) tick();
        n_checks++; if (bus.bid !== 1'b0) begin n_fail++; $display("FAIL reset_bid got %0b want 0", bus.bid); end
        n_checks++; if (bus.bid_amt !== 16'd0) begin n_fail++; $display("FAIL reset_bid_amt got %0d want 0", bus.bid_amt); end
        n_checks++; if (bus.retract !== 1'b0) begin n_fail++; $display("FAIL reset_retract got %0b want 0", bus.retract); end
        n_checks++; if (leading !== 1'b0) begin n_fail++; $display("FAIL reset_leading got %0b want 0", leading); end
        n_checks++; if (won !== 1'b0) begin n_fail++; $display("FAIL reset_won got %0b want 0", won); end
        n_checks++; if (last_err !== 2'b00) begin n_fail++; $display("FAIL reset_last_err got %0b want 00", last_err); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %0b want 0", timeout); end
        n_checks++; if (bid_count !== 8'd0) begin n_fail++; $display("FAIL reset_bid_count got %0d want 0", bid_count); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_accepted();
        limit = 16'd100; step_v = 16'd10; bus.max_bid = 32'd0; bus.balance = 32'd500;
        bus.round_active = 1'b1; en = 1'b1;
        tick();
        n_checks++; if (bus.bid !== 1'b1) begin n_fail++; $display("FAIL acc_bid got %0b want 1", bus.bid); end
        n_checks++; if (bus.bid_amt !== 16'd10) begin n_fail++; $display("FAIL acc_bid_amt got %0d want 10", bus.bid_amt); end
        tick();
        n_checks++; if (bus.bid !== 1'b0) begin n_fail++; $display("FAIL acc_single_pulse got %0b want 0", bus.bid); end
        tick();
        n_checks++; if (leading !== 1'b0) begin n_fail++; $display("FAIL acc_lead_early got %0b want 0", leading); end
        bus.ack = 1'b1; bus.err = 2'b00;
        tick();
        bus.ack = 1'b0;
        n_checks++; if (leading !== 1'b1) begin n_fail++; $display("FAIL acc_leading got %0b want 1", leading); end
        n_checks++; if (bid_count !== 8'd1) begin n_fail++; $display("FAIL acc_bid_count got %0d want 1", bid_count); end
    endtask

    task automatic test_outbid_limit();
        logic seen;
        bus.max_bid = 32'd95;
        tick();
        n_checks++; if (leading !== 1'b0) begin n_fail++; $display("FAIL outbid_leading got %0b want 0", leading); end
        seen = 1'b0;
        repeat (5) begin
            if (bus.bid === 1'b1) seen = 1'b1;
            tick();
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL priced_out_bid got %0b want 0", seen); end
        bus.max_bid = 32'd85;
        tick();
        n_checks++; if (bus.bid !== 1'b1) begin n_fail++; $display("FAIL rebid_bid got %0b want 1", bus.bid); end
        n_checks++; if (bus.bid_amt !== 16'd95) begin n_fail++; $display("FAIL rebid_amt got %0d want 95", bus.bid_amt); end
    endtask

    task automatic test_error_backoff();
        int n;
        tick();
        bus.ack = 1'b1; bus.err = 2'b10;
        tick();
        bus.ack = 1'b0; bus.err = 2'b00;
        n_checks++; if (last_err !== 2'b10) begin n_fail++; $display("FAIL err_last_err got %0b want 10", last_err); end
        wait_bid(20, n);
        n_checks++; if (n !== 5) begin n_fail++; $display("FAIL err_backoff_gap got %0d want 5", n); end
        n_checks++; if (bus.bid_amt !== 16'd95) begin n_fail++; $display("FAIL err_retry_amt got %0d want 95", bus.bid_amt); end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        while (timeout !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_checks++; if (n !== 16) begin n_fail++; $display("FAIL to_cycle got %0d want 16", n); end
        tick();
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_single_pulse got %0b want 0", timeout); end
        n_checks++; if (last_err !== 2'b11) begin n_fail++; $display("FAIL to_last_err got %0b want 11", last_err); end
        wait_bid(20, n);
        n_checks++; if (n !== 5) begin n_fail++; $display("FAIL to_retry_gap got %0d want 5", n); end
        tick();
        bus.ack = 1'b1; bus.err = 2'b00;
        tick();
        bus.ack = 1'b0;
        n_checks++; if (leading !== 1'b1) begin n_fail++; $display("FAIL to_then_lead got %0b want 1", leading); end
        n_checks++; if (bid_count !== 8'd2) begin n_fail++; $display("FAIL to_bid_count got %0d want 2", bid_count); end
    endtask

    task automatic test_retract();
        int n;
        en = 1'b0;
`ifdef BID_AGENT_RETRACT_EN
        tick();
        n_checks++; if (bus.retract !== 1'b1) begin n_fail++; $display("FAIL ret_pulse got %0b want 1", bus.retract); end
        tick();
        n_checks++; if (bus.retract !== 1'b0) begin n_fail++; $display("FAIL ret_single got %0b want 0", bus.retract); end
        bus.ack = 1'b1; bus.err = 2'b00;
        tick();
        bus.ack = 1'b0;
        n_checks++; if (leading !== 1'b0) begin n_fail++; $display("FAIL ret_leading got %0b want 0", leading); end
`else
        begin
            logic seen;
            seen = 1'b0;
            repeat (6) begin
                tick();
                if (bus.retract === 1'b1) seen = 1'b1;
            end
            n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL noret_pulse got %0b want 0", seen); end
            n_checks++; if (leading !== 1'b1) begin n_fail++; $display("FAIL noret_leading got %0b want 1", leading); end
        end
`endif
        en = 1'b1; limit = 16'd200; bus.max_bid = 32'd96;
        wait_bid(10, n);
        n_checks++; if (bus.bid !== 1'b1) begin n_fail++; $display("FAIL rearm_bid got %0b want 1", bus.bid); end
        n_checks++; if (bus.bid_amt !== 16'd106) begin n_fail++; $display("FAIL rearm_amt got %0d want 106", bus.bid_amt); end
    endtask

    task automatic test_round_end();
        logic seen;
        tick();
        bus.round_over = 1'b1; bus.win = 1'b1;
        tick();
        bus.round_over = 1'b0; bus.win = 1'b0; bus.round_active = 1'b0;
        n_checks++; if (won !== 1'b1) begin n_fail++; $display("FAIL end_won got %0b want 1", won); end
        n_checks++; if (leading !== 1'b0) begin n_fail++; $display("FAIL end_leading got %0b want 0", leading); end
        tick();
        bus.ack = 1'b1; bus.err = 2'b00;
        tick();
        bus.ack = 1'b0;
        n_checks++; if (leading !== 1'b0) begin n_fail++; $display("FAIL stray_ack_lead got %0b want 0", leading); end
        n_checks++; if (bid_count !== 8'd2) begin n_fail++; $display("FAIL stray_ack_count got %0d want 2", bid_count); end
        seen = 1'b0;
        repeat (4) begin
            if (bus.bid === 1'b1) seen = 1'b1;
            tick();
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL closed_round_bid got %0b want 0", seen); end
        bus.round_active = 1'b1;
        tick();
        n_checks++; if (bid_count !== 8'd0) begin n_fail++; $display("FAIL new_round_count got %0d want 0", bid_count); end
        n_checks++; if (won !== 1'b0) begin n_fail++; $display("FAIL new_round_won got %0b want 0", won); end
        n_checks++; if (bus.bid !== 1'b1) begin n_fail++; $display("FAIL new_round_bid got %0b want 1", bus.bid); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        tick();
        reset = 1'b1;
        #1;
        n_checks++; if (bus.bid_amt !== 16'd0) begin n_fail++; $display("FAIL rst_mid_amt got %0d want 0", bus.bid_amt); end
        n_checks++; if (last_err !== 2'b00) begin n_fail++; $display("FAIL rst_mid_last_err got %0b want 00", last_err); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_mid_timeout got %0b want 0", timeout); end
        n_checks++; if (leading !== 1'b0) begin n_fail++; $display("FAIL rst_mid_leading got %0b want 0", leading); end
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (bus.bid === 1'b1 || bus.retract === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pulse got %0b want 0", seen); end
        bus.round_active = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_boundary();
        logic seen;
        limit = 16'd51; step_v = 16'd0; bus.max_bid = 32'd50; bus.balance = 32'd50;
        en = 1'b1; bus.round_active = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (bus.bid === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL balance_block got %0b want 0", seen); end
        bus.balance = 32'd51;
        tick();
        n_checks++; if (bus.bid !== 1'b1) begin n_fail++; $display("FAIL edge_bid got %0b want 1", bus.bid); end
        n_checks++; if (bus.bid_amt !== 16'd51) begin n_fail++; $display("FAIL step0_amt got %0d want 51", bus.bid_amt); end
        tick();
        bus.ack = 1'b1; bus.err = 2'b00;
        tick();
        bus.ack = 1'b0;
        n_checks++; if (leading !== 1'b1) begin n_fail++; $display("FAIL edge_leading got %0b want 1", leading); end
        n_checks++; if (bid_count !== 8'd1) begin n_fail++; $display("FAIL edge_count got %0d want 1", bid_count); end
    endtask

    initial begin
        test_reset();
        test_accepted();
        test_outbid_limit();
        test_error_backoff();
        test_timeout();
        test_retract();
        test_round_end();
        test_reset_mid();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
